// File: rtl/lsb_queue.sv
// lsb_queue: in-order load/store queue between the decoder and memctrl.
// Entries wait in a circular buffer, snoop the CDB for their operands, and
// the head entry is walked through a small FSM: loads are issued straight to
// memctrl, stores are first reported to the ROB and written only after commit.
// Optional build macro: LSB_MISALIGN_CHK_EN traps misaligned head accesses
// back to the ROB instead of sending them to memctrl.

package lsb_queue_pkg;
    localparam int INST_OPT_W = 4;
    localparam logic [3:0] OPT_LB  = 4'd1;
    localparam logic [3:0] OPT_LH  = 4'd2;
    localparam logic [3:0] OPT_LW  = 4'd3;
    localparam logic [3:0] OPT_LBU = 4'd4;
    localparam logic [3:0] OPT_LHU = 4'd5;
    localparam logic [3:0] OPT_SB  = 4'd6;
    localparam logic [3:0] OPT_SH  = 4'd7;
    localparam logic [3:0] OPT_SW  = 4'd8;
endpackage

module lsb_queue
    import lsb_queue_pkg::*;
#(
    parameter int DEPTH_BIT   = 4,
    parameter int CDB_N       = 2,
    parameter int ROB_BIT     = 4,
    parameter int FULL_MARGIN = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       lsb_en,
    input  logic                       lsb_st,
    input  logic                       lsb_rb,
    output logic                       lsb_full,
    output logic                       lsb_empty,
    input  logic                       id_valid,
    input  logic [INST_OPT_W-1:0]      id_opt,
    input  logic [ROB_BIT-1:0]         id_src1,
    input  logic [ROB_BIT-1:0]         id_src2,
    input  logic [31:0]                id_val1,
    input  logic [31:0]                id_val2,
    input  logic [31:0]                id_imm,
    input  logic [ROB_BIT-1:0]         id_rob_idx,
    input  logic [CDB_N-1:0]           cdb_valid,
    input  logic [CDB_N*ROB_BIT-1:0]   cdb_src,
    input  logic [CDB_N*32-1:0]        cdb_val,
    output logic                       mc_ld_ena,
    output logic [31:0]                mc_ld_addr,
    output logic [3:0]                 mc_ld_len,
    output logic                       mc_ld_sext,
    output logic [ROB_BIT-1:0]         mc_ld_src,
    input  logic                       mc_ld_done,
    output logic                       mc_st_ena,
    output logic [31:0]                mc_st_addr,
    output logic [3:0]                 mc_st_len,
    output logic [31:0]                mc_st_data,
    input  logic                       mc_st_done,
    output logic                       rob_ena,
    output logic [ROB_BIT-1:0]         rob_src,
    output logic [31:0]                rob_val,
    output logic [31:0]                rob_addr,
    output logic                       rob_exc,
    output logic [ROB_BIT-1:0]         rob_st_idx,
    input  logic                       rob_st_rdy
);

    localparam int DEPTH = 1 << DEPTH_BIT;
    localparam logic [DEPTH_BIT:0]   CNT_MAX = (DEPTH_BIT+1)'(DEPTH);
    localparam logic [DEPTH_BIT:0]   FULL_TH = (DEPTH_BIT+1)'(DEPTH - FULL_MARGIN);
    localparam logic [DEPTH_BIT:0]   CNT_ZERO = {(DEPTH_BIT+1){1'b0}};
    localparam logic [DEPTH_BIT:0]   CNT_ONE  = {{DEPTH_BIT{1'b0}}, 1'b1};
    localparam logic [DEPTH_BIT-1:0] PTR_ONE  = {{(DEPTH_BIT-1){1'b0}}, 1'b1};
    localparam logic [ROB_BIT-1:0]   TAG_ZERO = {ROB_BIT{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LD_WAIT   = 2'd1,
        S_ST_COMMIT = 2'd2,
        S_ST_WRITE  = 2'd3
    } state_t;

    // ---------------------------------------------------------------- helpers
    function automatic logic opt_is_load(input logic [3:0] opt);
        logic r;
        case (opt)
            OPT_LB, OPT_LH, OPT_LW, OPT_LBU, OPT_LHU: r = 1'b1;
            default:                                  r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic opt_is_store(input logic [3:0] opt);
        logic r;
        case (opt)
            OPT_SB, OPT_SH, OPT_SW: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] opt_len(input logic [3:0] opt);
        logic [3:0] r;
        case (opt)
            OPT_LB, OPT_LBU, OPT_SB: r = 4'd0;
            OPT_LH, OPT_LHU, OPT_SH: r = 4'd1;
            OPT_LW, OPT_SW:          r = 4'd3;
            default:                 r = 4'd0;
        endcase
        return r;
    endfunction

    // Any valid channel carrying this (non-zero) tag?
    function automatic logic cdb_hit(input logic [ROB_BIT-1:0]       tag,
                                     input logic [CDB_N-1:0]         v,
                                     input logic [CDB_N*ROB_BIT-1:0] s);
        logic r;
        r = 1'b0;
        for (int k = 0; k < CDB_N; k++) begin
            if (v[k] && (tag != TAG_ZERO) && (s[k*ROB_BIT +: ROB_BIT] == tag)) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    // Value from the lowest-indexed matching channel (scan high to low so the
    // lowest index is written last), or dflt when nothing matches.
    function automatic logic [31:0] cdb_pick(input logic [ROB_BIT-1:0]       tag,
                                             input logic [31:0]              dflt,
                                             input logic [CDB_N-1:0]         v,
                                             input logic [CDB_N*ROB_BIT-1:0] s,
                                             input logic [CDB_N*32-1:0]      d);
        logic [31:0] r;
        r = dflt;
        for (int k = CDB_N - 1; k >= 0; k--) begin
            if (v[k] && (tag != TAG_ZERO) && (s[k*ROB_BIT +: ROB_BIT] == tag)) begin
                r = d[k*32 +: 32];
            end
        end
        return r;
    endfunction

`ifdef LSB_MISALIGN_CHK_EN
    function automatic logic is_misaligned(input logic [3:0] len, input logic [1:0] a);
        logic r;
        case (len)
            4'd1:    r = a[0];
            4'd3:    r = (a != 2'd0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction
`endif

    // ---------------------------------------------------------------- storage
    logic [DEPTH-1:0]      busy_r;
    logic [3:0]            opt_r  [DEPTH];
    logic [ROB_BIT-1:0]    src1_r [DEPTH];
    logic [ROB_BIT-1:0]    src2_r [DEPTH];
    logic [31:0]           val1_r [DEPTH];
    logic [31:0]           val2_r [DEPTH];
    logic [31:0]           imm_r  [DEPTH];
    logic [ROB_BIT-1:0]    dest_r [DEPTH];

    logic [DEPTH_BIT-1:0]  head_r;
    logic [DEPTH_BIT-1:0]  tail_r;
    logic [DEPTH_BIT:0]    count_r;
    state_t                state_r;
    state_t                state_nxt;

    logic                  fsm_go_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  misalign_s;

    logic [3:0]            h_opt_s;
    logic [ROB_BIT-1:0]    h_src1_s;
    logic [ROB_BIT-1:0]    h_src2_s;
    logic [31:0]           h_val2_s;
    logic [ROB_BIT-1:0]    h_dest_s;
    logic [31:0]           h_addr_s;
    logic [3:0]            h_len_s;

    logic                  ld_ena_nxt, ld_sext_nxt, st_ena_nxt, rob_ena_nxt;
    logic [31:0]           ld_addr_nxt, st_addr_nxt, st_data_nxt, rob_val_nxt, rob_addr_nxt;
    logic [3:0]            ld_len_nxt, st_len_nxt;
    logic [ROB_BIT-1:0]    ld_src_nxt, rob_src_nxt, st_idx_nxt;

    assign empty_s   = (count_r == CNT_ZERO);
    assign lsb_empty = empty_s;
    assign lsb_full  = (count_r >= FULL_TH);
    assign fsm_go_s  = lsb_en && !lsb_st;

    assign h_opt_s   = opt_r[head_r];
    assign h_src1_s  = src1_r[head_r];
    assign h_src2_s  = src2_r[head_r];
    assign h_val2_s  = val2_r[head_r];
    assign h_dest_s  = dest_r[head_r];
    assign h_addr_s  = val1_r[head_r] + imm_r[head_r];
    assign h_len_s   = opt_len(h_opt_s);

`ifdef LSB_MISALIGN_CHK_EN
    assign misalign_s = is_misaligned(h_len_s, h_addr_s[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    // Accept a push only when running, not squashing, and there is room
    assign push_s = rdy && fsm_go_s && !lsb_rb && id_valid &&
                    ((count_r != CNT_MAX) || pop_s);

`ifdef LSB_MISALIGN_CHK_EN
    logic rob_exc_nxt;
    logic rob_exc_r;
    assign rob_exc = rob_exc_r;
`else
    assign rob_exc = 1'b0;
`endif

    // Head FSM: next state, pop and next values of the registered outputs
    always_comb begin
        state_nxt    = state_r;
        pop_s        = 1'b0;
        ld_ena_nxt   = mc_ld_ena;
        ld_addr_nxt  = mc_ld_addr;
        ld_len_nxt   = mc_ld_len;
        ld_sext_nxt  = mc_ld_sext;
        ld_src_nxt   = mc_ld_src;
        st_ena_nxt   = mc_st_ena;
        st_addr_nxt  = mc_st_addr;
        st_len_nxt   = mc_st_len;
        st_data_nxt  = mc_st_data;
        rob_ena_nxt  = 1'b0;
        rob_src_nxt  = rob_src;
        rob_val_nxt  = rob_val;
        rob_addr_nxt = rob_addr;
        st_idx_nxt   = rob_st_idx;
`ifdef LSB_MISALIGN_CHK_EN
        rob_exc_nxt  = 1'b0;
`endif
        if (lsb_rb) begin
            if (state_r == S_ST_WRITE) begin
                // A committed store must still reach memory
                if (mc_st_done) begin
                    pop_s      = 1'b1;
                    st_ena_nxt = 1'b0;
                    state_nxt  = S_IDLE;
                end else begin
                    state_nxt  = S_ST_WRITE;
                end
            end else begin
                state_nxt  = S_IDLE;
                ld_ena_nxt = 1'b0;
                st_ena_nxt = 1'b0;
                st_idx_nxt = TAG_ZERO;
            end
        end else if (fsm_go_s) begin
            case (state_r)
                S_IDLE: begin
                    if (empty_s) begin
                        state_nxt = S_IDLE;
                    end else if (opt_is_load(h_opt_s) && (h_src1_s == TAG_ZERO)) begin
                        if (misalign_s) begin
                            pop_s        = 1'b1;
                            rob_ena_nxt  = 1'b1;
                            rob_src_nxt  = h_dest_s;
                            rob_val_nxt  = 32'd0;
                            rob_addr_nxt = h_addr_s;
`ifdef LSB_MISALIGN_CHK_EN
                            rob_exc_nxt  = 1'b1;
`endif
                        end else begin
                            ld_ena_nxt  = 1'b1;
                            ld_addr_nxt = h_addr_s;
                            ld_len_nxt  = h_len_s;
                            ld_sext_nxt = (h_opt_s == OPT_LB) || (h_opt_s == OPT_LH);
                            ld_src_nxt  = h_dest_s;
                            state_nxt   = S_LD_WAIT;
                        end
                    end else if (opt_is_store(h_opt_s) && (h_src1_s == TAG_ZERO) &&
                                 (h_src2_s == TAG_ZERO)) begin
                        rob_ena_nxt  = 1'b1;
                        rob_src_nxt  = h_dest_s;
                        rob_addr_nxt = h_addr_s;
                        if (misalign_s) begin
                            pop_s       = 1'b1;
                            rob_val_nxt = 32'd0;
`ifdef LSB_MISALIGN_CHK_EN
                            rob_exc_nxt = 1'b1;
`endif
                        end else begin
                            rob_val_nxt = h_val2_s;
                            st_idx_nxt  = h_dest_s;
                            state_nxt   = S_ST_COMMIT;
                        end
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                S_LD_WAIT: begin
                    if (mc_ld_done) begin
                        ld_ena_nxt = 1'b0;
                        pop_s      = 1'b1;
                        state_nxt  = S_IDLE;
                    end else begin
                        state_nxt  = S_LD_WAIT;
                    end
                end
                S_ST_COMMIT: begin
                    if (rob_st_rdy) begin
                        st_ena_nxt  = 1'b1;
                        st_addr_nxt = h_addr_s;
                        st_len_nxt  = h_len_s;
                        st_data_nxt = h_val2_s;
                        st_idx_nxt  = TAG_ZERO;
                        state_nxt   = S_ST_WRITE;
                    end else begin
                        state_nxt   = S_ST_COMMIT;
                    end
                end
                S_ST_WRITE: begin
                    if (mc_st_done) begin
                        st_ena_nxt = 1'b0;
                        pop_s      = 1'b1;
                        state_nxt  = S_IDLE;
                    end else begin
                        state_nxt  = S_ST_WRITE;
                    end
                end
                default: begin
                    state_nxt  = S_IDLE;
                    ld_ena_nxt = 1'b0;
                    st_ena_nxt = 1'b0;
                end
            endcase
        end else begin
            state_nxt = state_r;
        end
    end

    // FSM state and registered memctrl/ROB outputs; rdy low freezes them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            mc_ld_ena  <= 1'b0;
            mc_ld_addr <= 32'd0;
            mc_ld_len  <= 4'd0;
            mc_ld_sext <= 1'b0;
            mc_ld_src  <= TAG_ZERO;
            mc_st_ena  <= 1'b0;
            mc_st_addr <= 32'd0;
            mc_st_len  <= 4'd0;
            mc_st_data <= 32'd0;
            rob_ena    <= 1'b0;
            rob_src    <= TAG_ZERO;
            rob_val    <= 32'd0;
            rob_addr   <= 32'd0;
            rob_st_idx <= TAG_ZERO;
        end else if (rdy) begin
            state_r    <= state_nxt;
            mc_ld_ena  <= ld_ena_nxt;
            mc_ld_addr <= ld_addr_nxt;
            mc_ld_len  <= ld_len_nxt;
            mc_ld_sext <= ld_sext_nxt;
            mc_ld_src  <= ld_src_nxt;
            mc_st_ena  <= st_ena_nxt;
            mc_st_addr <= st_addr_nxt;
            mc_st_len  <= st_len_nxt;
            mc_st_data <= st_data_nxt;
            rob_ena    <= rob_ena_nxt;
            rob_src    <= rob_src_nxt;
            rob_val    <= rob_val_nxt;
            rob_addr   <= rob_addr_nxt;
            rob_st_idx <= st_idx_nxt;
        end else begin
            // the report is a single pulse even while frozen
            rob_ena    <= 1'b0;
        end
    end

`ifdef LSB_MISALIGN_CHK_EN
    // Misalignment flag accompanies its rob_ena pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rob_exc_r <= 1'b0;
        end else if (rdy) begin
            rob_exc_r <= rob_exc_nxt;
        end else begin
            rob_exc_r <= 1'b0;
        end
    end
`endif

    // Queue entries: CDB snoop, push at tail, pop at head, rollback
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= {DEPTH_BIT{1'b0}};
            tail_r  <= {DEPTH_BIT{1'b0}};
            count_r <= CNT_ZERO;
            busy_r  <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                opt_r[i]  <= 4'd0;
                src1_r[i] <= TAG_ZERO;
                src2_r[i] <= TAG_ZERO;
                val1_r[i] <= 32'd0;
                val2_r[i] <= 32'd0;
                imm_r[i]  <= 32'd0;
                dest_r[i] <= TAG_ZERO;
            end
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_r[i] && cdb_hit(src1_r[i], cdb_valid, cdb_src)) begin
                    src1_r[i] <= TAG_ZERO;
                    val1_r[i] <= cdb_pick(src1_r[i], val1_r[i], cdb_valid, cdb_src, cdb_val);
                end
                if (busy_r[i] && cdb_hit(src2_r[i], cdb_valid, cdb_src)) begin
                    src2_r[i] <= TAG_ZERO;
                    val2_r[i] <= cdb_pick(src2_r[i], val2_r[i], cdb_valid, cdb_src, cdb_val);
                end
            end
            if (lsb_rb) begin
                if (state_r == S_ST_WRITE) begin
                    // keep only the store being written
                    for (int i = 0; i < DEPTH; i++) begin
                        if (DEPTH_BIT'(i) != head_r) begin
                            busy_r[i] <= 1'b0;
                        end
                    end
                    tail_r <= head_r + PTR_ONE;
                    if (pop_s) begin
                        busy_r[head_r] <= 1'b0;
                        head_r         <= head_r + PTR_ONE;
                        count_r        <= CNT_ZERO;
                    end else begin
                        count_r        <= CNT_ONE;
                    end
                end else begin
                    busy_r  <= {DEPTH{1'b0}};
                    head_r  <= tail_r;
                    count_r <= CNT_ZERO;
                end
            end else begin
                if (pop_s) begin
                    busy_r[head_r] <= 1'b0;
                    head_r         <= head_r + PTR_ONE;
                end
                if (push_s) begin
                    // forwarded push value wins over a same-cycle snoop
                    busy_r[tail_r] <= 1'b1;
                    opt_r[tail_r]  <= id_opt;
                    src1_r[tail_r] <= cdb_hit(id_src1, cdb_valid, cdb_src) ? TAG_ZERO : id_src1;
                    val1_r[tail_r] <= cdb_pick(id_src1, id_val1, cdb_valid, cdb_src, cdb_val);
                    src2_r[tail_r] <= cdb_hit(id_src2, cdb_valid, cdb_src) ? TAG_ZERO : id_src2;
                    val2_r[tail_r] <= cdb_pick(id_src2, id_val2, cdb_valid, cdb_src, cdb_val);
                    imm_r[tail_r]  <= id_imm;
                    dest_r[tail_r] <= id_rob_idx;
                    tail_r         <= tail_r + PTR_ONE;
                end
                count_r <= count_r + {{DEPTH_BIT{1'b0}}, push_s} - {{DEPTH_BIT{1'b0}}, pop_s};
            end
        end
    end

endmodule

// File: tb/tb_lsb_queue.sv
// Directed testbench for lsb_queue (default parameters). Inputs are driven
// 1 ns after the rising edge and outputs sampled there as well.
module tb_lsb_queue;
    import lsb_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, lsb_en, lsb_st, lsb_rb;
    logic        lsb_full, lsb_empty;
    logic        id_valid;
    logic [3:0]  id_opt, id_src1, id_src2, id_rob_idx;
    logic [31:0] id_val1, id_val2, id_imm;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_src;
    logic [63:0] cdb_val;
    logic        mc_ld_ena, mc_ld_sext, mc_ld_done;
    logic [31:0] mc_ld_addr;
    logic [3:0]  mc_ld_len, mc_ld_src;
    logic        mc_st_ena, mc_st_done;
    logic [31:0] mc_st_addr, mc_st_data;
    logic [3:0]  mc_st_len;
    logic        rob_ena, rob_exc, rob_st_rdy;
    logic [3:0]  rob_src, rob_st_idx;
    logic [31:0] rob_val, rob_addr;

    int total = 0;
    int bad   = 0;

    logic [3:0] ld_opts [5] = '{OPT_LB, OPT_LH, OPT_LW, OPT_LBU, OPT_LHU};
    logic [3:0] ld_lens [5] = '{4'd0, 4'd1, 4'd3, 4'd0, 4'd1};
    logic       ld_sexts[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    lsb_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy), .lsb_en(lsb_en), .lsb_st(lsb_st), .lsb_rb(lsb_rb),
        .lsb_full(lsb_full), .lsb_empty(lsb_empty),
        .id_valid(id_valid), .id_opt(id_opt), .id_src1(id_src1), .id_src2(id_src2),
        .id_val1(id_val1), .id_val2(id_val2), .id_imm(id_imm), .id_rob_idx(id_rob_idx),
        .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_val(cdb_val),
        .mc_ld_ena(mc_ld_ena), .mc_ld_addr(mc_ld_addr), .mc_ld_len(mc_ld_len),
        .mc_ld_sext(mc_ld_sext), .mc_ld_src(mc_ld_src), .mc_ld_done(mc_ld_done),
        .mc_st_ena(mc_st_ena), .mc_st_addr(mc_st_addr), .mc_st_len(mc_st_len),
        .mc_st_data(mc_st_data), .mc_st_done(mc_st_done),
        .rob_ena(rob_ena), .rob_src(rob_src), .rob_val(rob_val), .rob_addr(rob_addr),
        .rob_exc(rob_exc), .rob_st_idx(rob_st_idx), .rob_st_rdy(rob_st_rdy)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] opt, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                        input logic [3:0] dest);
        id_valid = 1'b1; id_opt = opt; id_src1 = s1; id_src2 = s2;
        id_val1 = v1; id_val2 = v2; id_imm = imm; id_rob_idx = dest;
        tick();
        id_valid = 1'b0;
    endtask

    task automatic wait_ld(input string tag, input int budget);
        int n = 0;
        while (!mc_ld_ena && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(mc_ld_ena), 32'd1);
    endtask

    task automatic pop_ld();
        mc_ld_done = 1'b1;
        tick();
        mc_ld_done = 1'b0;
    endtask

    task automatic cdb_clear();
        cdb_valid = 2'b00; cdb_src = 8'h00; cdb_val = 64'd0;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; lsb_en = 1'b1; lsb_st = 1'b0; lsb_rb = 1'b0;
        id_valid = 1'b0; id_opt = 4'd0; id_src1 = 4'd0; id_src2 = 4'd0;
        id_val1 = 32'd0; id_val2 = 32'd0; id_imm = 32'd0; id_rob_idx = 4'd0;
        mc_ld_done = 1'b0; mc_st_done = 1'b0; rob_st_rdy = 1'b0;
        cdb_clear();
        #3;
        check_eq("rst_empty",  32'(lsb_empty),  32'd1);
        check_eq("rst_full",   32'(lsb_full),   32'd0);
        check_eq("rst_ld_ena", 32'(mc_ld_ena),  32'd0);
        check_eq("rst_st_ena", 32'(mc_st_ena),  32'd0);
        check_eq("rst_rob",    32'(rob_ena),    32'd0);
        check_eq("rst_st_idx", 32'(rob_st_idx), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // LW 0x1000+8, memctrl slow to answer
        push(OPT_LW, 4'd0, 4'd0, 32'h1000, 32'd0, 32'd8, 4'd3);
        check_eq("lw_lat_c1",  32'(mc_ld_ena),  32'd0);
        check_eq("lw_nonempty", 32'(lsb_empty), 32'd0);
        tick();
        check_eq("lw_lat_c2",  32'(mc_ld_ena),  32'd1);
        check_eq("lw_addr",    mc_ld_addr,      32'h1008);
        check_eq("lw_len",     32'(mc_ld_len),  32'd3);
        check_eq("lw_sext",    32'(mc_ld_sext), 32'd0);
        check_eq("lw_src",     32'(mc_ld_src),  32'd3);
        repeat (5) tick();
        check_eq("lw_hold",    32'(mc_ld_ena),  32'd1);
        pop_ld();
        check_eq("lw_drop",    32'(mc_ld_ena),  32'd0);
        check_eq("lw_popped",  32'(lsb_empty),  32'd1);

        // asynchronous reset while a load is outstanding
        push(OPT_LW, 4'd0, 4'd0, 32'h2000, 32'd0, 32'd0, 4'd2);
        tick();
        check_eq("ar_pre_ena", 32'(mc_ld_ena),  32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("ar_ld_ena",  32'(mc_ld_ena),  32'd0);
        check_eq("ar_ld_addr", mc_ld_addr,      32'd0);
        check_eq("ar_empty",   32'(lsb_empty),  32'd1);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // SH whose data arrives on CDB channel 1
        push(OPT_SH, 4'd0, 4'd5, 32'h2000, 32'd0, 32'd2, 4'd6);
        cdb_valid = 2'b10; cdb_src = {4'd5, 4'd0}; cdb_val = {32'h0000BEEF, 32'h0};
        tick();
        cdb_clear();
        begin
            int n = 0;
            while (!rob_ena && n < 8) begin tick(); n++; end
        end
        check_eq("sh_rob_ena", 32'(rob_ena),    32'd1);
        check_eq("sh_rob_val", rob_val,         32'h0000BEEF);
        check_eq("sh_rob_addr", rob_addr,       32'h2002);
        check_eq("sh_rob_src", 32'(rob_src),    32'd6);
        check_eq("sh_rob_exc", 32'(rob_exc),    32'd0);
        check_eq("sh_st_idx",  32'(rob_st_idx), 32'd6);
        tick();
        check_eq("sh_pulse",   32'(rob_ena),    32'd0);
        check_eq("sh_no_early", 32'(mc_st_ena), 32'd0);
        rob_st_rdy = 1'b1;
        tick();
        rob_st_rdy = 1'b0;
        check_eq("sh_st_ena",  32'(mc_st_ena),  32'd1);
        check_eq("sh_st_len",  32'(mc_st_len),  32'd1);
        check_eq("sh_st_data", mc_st_data,      32'h0000BEEF);
        check_eq("sh_st_addr", mc_st_addr,      32'h2002);
        check_eq("sh_idx_clr", 32'(rob_st_idx), 32'd0);
        mc_st_done = 1'b1;
        tick();
        mc_st_done = 1'b0;
        check_eq("sh_st_drop", 32'(mc_st_ena),  32'd0);
        check_eq("sh_empty",   32'(lsb_empty),  32'd1);

        // push-time forwarding, both channels match: channel 0 wins
        cdb_valid = 2'b11; cdb_src = {4'd3, 4'd3}; cdb_val = {32'h4000, 32'h3000};
        push(OPT_LW, 4'd3, 4'd0, 32'd0, 32'd0, 32'h10, 4'd1);
        cdb_clear();
        wait_ld("fwd_ena", 6);
        check_eq("fwd_addr", mc_ld_addr, 32'h3010);
        pop_ld();

        // tag 0 on the CDB must not overwrite a ready operand
        cdb_valid = 2'b01; cdb_src = {4'd0, 4'd0}; cdb_val = {32'h0, 32'h999};
        push(OPT_LB, 4'd0, 4'd0, 32'h100, 32'd0, 32'd1, 4'd2);
        cdb_clear();
        wait_ld("tag0_ena", 6);
        check_eq("tag0_addr", mc_ld_addr,      32'h101);
        check_eq("lb_len",    32'(mc_ld_len),  32'd0);
        check_eq("lb_sext",   32'(mc_ld_sext), 32'd1);
        pop_ld();

        // stall blocks a push
        lsb_st = 1'b1;
        push(OPT_LW, 4'd0, 4'd0, 32'h0, 32'd0, 32'd0, 4'd1);
        lsb_st = 1'b0;
        check_eq("stall_nopush", 32'(lsb_empty), 32'd1);

        // fill to 16 (full warning at 13), then drain all 16 across the wrap
        for (int i = 0; i < 16; i++) begin
            push(ld_opts[i % 5], 4'd0, 4'd0, 32'h4000 + 32'(i) * 32'd16, 32'd0,
                 32'(i) * 32'd4, 4'(i % 15 + 1));
            if (i == 11) check_eq("full_at12", 32'(lsb_full), 32'd0);
            if (i == 12) check_eq("full_at13", 32'(lsb_full), 32'd1);
        end
        check_eq("full_at16",  32'(lsb_full),  32'd1);
        for (int i = 0; i < 16; i++) begin
            wait_ld("drain_ena", 6);
            check_eq("drain_addr", mc_ld_addr,      32'h4000 + 32'(i) * 32'd20);
            check_eq("drain_len",  32'(mc_ld_len),  32'(ld_lens[i % 5]));
            check_eq("drain_sext", 32'(mc_ld_sext), 32'(ld_sexts[i % 5]));
            pop_ld();
        end
        check_eq("drain_empty", 32'(lsb_empty), 32'd1);
        check_eq("drain_full",  32'(lsb_full),  32'd0);

        // rollback while a committed store is being written
        push(OPT_SW, 4'd0, 4'd0, 32'h5000, 32'hCAFE, 32'd4, 4'd9);
        push(OPT_LW, 4'd7, 4'd0, 32'd0, 32'd0, 32'd0, 4'd10);
        push(OPT_LW, 4'd7, 4'd0, 32'd0, 32'd0, 32'd0, 4'd11);
        push(OPT_LW, 4'd7, 4'd0, 32'd0, 32'd0, 32'd0, 4'd12);
        check_eq("rb_commit_idx", 32'(rob_st_idx), 32'd9);
        rob_st_rdy = 1'b1;
        tick();
        rob_st_rdy = 1'b0;
        check_eq("rb_st_ena", 32'(mc_st_ena), 32'd1);
        lsb_rb = 1'b1;
        tick();
        lsb_rb = 1'b0;
        check_eq("rb_st_hold", 32'(mc_st_ena),  32'd1);
        check_eq("rb_st_addr", mc_st_addr,      32'h5004);
        check_eq("rb_st_data", mc_st_data,      32'h0000CAFE);
        check_eq("rb_keep1",   32'(lsb_empty),  32'd0);
        mc_st_done = 1'b1;
        tick();
        mc_st_done = 1'b0;
        check_eq("rb_st_done", 32'(mc_st_ena),  32'd0);
        check_eq("rb_empty",   32'(lsb_empty),  32'd1);
        cdb_valid = 2'b01; cdb_src = {4'd0, 4'd7}; cdb_val = {32'h0, 32'h77};
        tick();
        cdb_clear();
        repeat (3) tick();
        check_eq("rb_young_gone", 32'(mc_ld_ena), 32'd0);

        // rollback beats a same-cycle push and squashes a waiting load
        push(OPT_LW, 4'd7, 4'd0, 32'd0, 32'd0, 32'd0, 4'd5);
        id_valid = 1'b1; lsb_rb = 1'b1;
        tick();
        id_valid = 1'b0; lsb_rb = 1'b0;
        check_eq("rbp_empty", 32'(lsb_empty), 32'd1);
        cdb_valid = 2'b01; cdb_src = {4'd0, 4'd7}; cdb_val = {32'h0, 32'h77};
        tick();
        cdb_clear();
        repeat (3) tick();
        check_eq("rbp_no_ld", 32'(mc_ld_ena), 32'd0);

        // misaligned word load
        push(OPT_LW, 4'd0, 4'd0, 32'h1000, 32'd0, 32'd2, 4'd4);
`ifdef LSB_MISALIGN_CHK_EN
        begin
            logic ld_seen = 1'b0;
            logic exc_seen = 1'b0;
            logic [31:0] exc_addr = 32'd0;
            for (int n = 0; n < 6; n++) begin
                if (mc_ld_ena) ld_seen = 1'b1;
                if (rob_ena) begin exc_seen = rob_exc; exc_addr = rob_addr; end
                tick();
            end
            check_eq("mis_exc",   32'(exc_seen),  32'd1);
            check_eq("mis_addr",  exc_addr,       32'h1002);
            check_eq("mis_no_ld", 32'(ld_seen),   32'd0);
            check_eq("mis_empty", 32'(lsb_empty), 32'd1);
        end
`else
        wait_ld("mis_ena", 6);
        check_eq("mis_addr", mc_ld_addr,   32'h1002);
        check_eq("mis_exc",  32'(rob_exc), 32'd0);
        pop_ld();
        check_eq("mis_empty", 32'(lsb_empty), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
